// File: rtl/uart_tx_ser_if.sv
// FIFO-side, baud-tick and serial-line signals of the UART transmit serializer.
// The master drives ticks and FIFO data; the slave is the serializer itself.
interface uart_tx_ser_if #(
  parameter int DBIT = 8
);
  logic            s_tick;
  logic            fifo_not_empty;
  logic [DBIT-1:0] fifo_r_data;
  logic            fifo_rd_en;
  logic            tx;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (
    output s_tick, fifo_not_empty, fifo_r_data,
    input  fifo_rd_en, tx, tx_busy, tx_done_tick
  );

  modport slave (
    input  s_tick, fifo_not_empty, fifo_r_data,
    output fifo_rd_en, tx, tx_busy, tx_done_tick
  );
endinterface

// File: rtl/uart_tx_ser.sv
// UART transmit serializer: pops one FIFO word per frame and shifts it out LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_ser #(
  parameter int DBIT    = 8,
  parameter int OS      = 16,
  parameter int SB_TICK = 16
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_ser_if.slave bus
);

  localparam int S_MAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int SW    = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] OS_LAST = SW'(OS - 1);
  localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] START  = 3'd3;
  localparam logic [2:0] DATA   = 3'd4;
  localparam logic [2:0] STOP   = 3'd6;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd5;
`endif

  logic [2:0]      state_reg, state_next;
  logic [SW-1:0]   s_cnt, s_next;
  logic [NW-1:0]   n_cnt, n_next;
  logic [DBIT-1:0] b_reg, b_next;
  logic            tx_reg, tx_next;
  logic            done_reg, done_next;
`ifdef UART_TX_PARITY_EN
  logic            par_reg, par_next;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      s_cnt     <= '0;
      n_cnt     <= '0;
      b_reg     <= '0;
      tx_reg    <= 1'b1;
      done_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      s_cnt     <= s_next;
      n_cnt     <= n_next;
      b_reg     <= b_next;
      tx_reg    <= tx_next;
      done_reg  <= done_next;
`ifdef UART_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_cnt;
    n_next     = n_cnt;
    b_next     = b_reg;
    done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next   = par_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.fifo_not_empty) state_next = FETCH;
      end
      FETCH: begin
        state_next = LOAD;
      end
      LOAD: begin
        // fifo_r_data is the registered word popped during FETCH
        b_next     = bus.fifo_r_data;
        s_next     = '0;
        n_next     = '0;
`ifdef UART_TX_PARITY_EN
        par_next   = ^bus.fifo_r_data;
`endif
        state_next = START;
      end
      START: begin
        if (bus.s_tick) begin
          if (s_cnt == OS_LAST) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_cnt == OS_LAST) begin
            s_next = '0;
            b_next = b_reg >> 1;
            if (n_cnt == N_LAST) begin
              n_next     = '0;
`ifdef UART_TX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n_cnt + 1'b1;
            end
          end else begin
            s_next = s_cnt + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bus.s_tick) begin
          if (s_cnt == OS_LAST) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (bus.s_tick) begin
          if (s_cnt == SB_LAST) begin
            s_next     = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        s_next     = '0;
        n_next     = '0;
      end
    endcase
  end

  // tx is registered from the next state so the line changes on the same edge as the FSM
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_next;
`endif
      default: tx_next = 1'b1;
    endcase
  end

  assign bus.fifo_rd_en   = (state_reg == FETCH);
  assign bus.tx_busy      = (state_reg != IDLE);
  assign bus.tx           = tx_reg;
  assign bus.tx_done_tick = done_reg;

endmodule
